// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding, default width and counter sizing
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return w < 2 ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand request and result handshakes of the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// FULL_ADDER: gate-level one-bit full adder cell
module FULL_ADDER (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencing one full-adder cell LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0] cnt;
  logic cy, ov, fs, fc;
  FULL_ADDER u_fa (.a(ra[0]), .b(rb[0]), .ci(cy), .s(fs), .co(fc));
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and handshake decode
  always_comb begin
    state_nxt = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                state == RUN  ? (cnt == LAST ? DONE : RUN) :
                                (bus.out_ready ? IDLE : DONE);
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
  end
  // operand load on accept, then one bit-step per RUN cycle; the carry flop doubles as carry_out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      res <= '0;
      cnt <= '0;
      cy  <= 1'b0;
      ov  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      ra  <= bus.a;
      rb  <= bus.sub ? ~bus.b : bus.b;
      cy  <= bus.sub | bus.carry_in;
      cnt <= '0;
      res <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      res <= {fs, res[WIDTH-1:1]};
      cy  <= fc;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == LAST) ov <= cy ^ fc;
    end
  assign bus.sum       = res;
  assign bus.carry_out = cy;
  assign bus.overflow  = ov;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and model-checked tests of the bit-serial adder controller
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_op(input logic [7:0] ia, ib, input logic isub, icin,
                       output logic [7:0] os, output logic oco, oov,
                       output int lat, output int acc);
    bus.a = ia; bus.b = ib; bus.sub = isub; bus.carry_in = icin; bus.in_valid = 1'b1;
    lat = -1; acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.a = 8'hA5; bus.b = 8'h5A; bus.sub = ~isub; bus.carry_in = ~icin;
    if (acc < 0) return;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    os = bus.sum; oco = bus.carry_out; oov = bus.overflow;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.carry_in = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
    checks++; if (bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.carry_out, bus.overflow); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_arith;
    logic [7:0] va [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h05};
    logic [7:0] vb [6] = '{8'h0F, 8'h01, 8'h01, 8'h07, 8'h01, 8'h07};
    logic       vs [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic       vc [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] es [6] = '{8'h4B, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'hFE};
    logic       ec [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic       eo [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] s;
    logic co, ov;
    int lat, acc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_op(va[k], vb[k], vs[k], vc[k], s, co, ov, lat, acc);
      checks++; if (lat !== W) begin failures++; $display("FAIL arith%0d_latency got=%0d exp=%0d", k, lat, W); end
      checks++; if (s !== es[k]) begin failures++; $display("FAIL arith%0d_sum got=%h exp=%h", k, s, es[k]); end
      checks++; if (co !== ec[k]) begin failures++; $display("FAIL arith%0d_carry got=%b exp=%b", k, co, ec[k]); end
      checks++; if (ov !== eo[k]) begin failures++; $display("FAIL arith%0d_overflow got=%b exp=%b", k, ov, eo[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [7:0] s;
    logic co, ov;
    int lat, acc0, acc1;
    bus.out_ready = 1'b0;
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, acc0);
    checks++; if (s !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin failures++; $display("FAIL bp_result got=%h/%b/%b exp=80/0/1", s, co, ov); end
    for (int i = 0; i < 5; i++) begin
      bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_handshake got=%b%b%b exp=101", i, bus.out_valid, bus.in_ready, bus.busy); end
      checks++; if (bus.sum !== 8'h80 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_stable got=%h/%b/%b exp=80/0/1", i, bus.sum, bus.carry_out, bus.overflow); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 1'b0, s, co, ov, lat, acc1);
    checks++; if (s !== 8'h03 || co !== 1'b0 || ov !== 1'b0) begin failures++; $display("FAIL bp_next_result got=%h/%b/%b exp=03/0/0", s, co, ov); end
    checks++; if (acc1 - acc0 < W + 2) begin failures++; $display("FAIL bp_interval got=%0d exp>=%0d", acc1 - acc0, W + 2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] s;
    logic co, ov;
    int lat, acc;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sub = 1'b0; bus.carry_in = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.sum !== 8'h80 || bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_partial got=%h/%b exp=80/1", bus.sum, bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 8'h00) begin failures++; $display("FAIL midrst_clear got=%b/%b/%h exp=0/0/00", bus.out_valid, bus.busy, bus.sum); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, s, co, ov, lat, acc);
    checks++; if (s !== 8'h02 || co !== 1'b0 || ov !== 1'b0 || lat !== W) begin failures++; $display("FAIL midrst_after got=%h/%b/%b lat=%0d exp=02/0/0 lat=%0d", s, co, ov, lat, W); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] s, ra, rb, bb, es;
    logic [8:0] full;
    logic co, ov, rs, rc, eo;
    int lat, acc, prev;
    bus.out_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {8'h00, rs | rc};
      es = full[7:0];
      eo = (ra[7] == bb[7]) && (es[7] != ra[7]);
      do_op(ra, rb, rs, rc, s, co, ov, lat, acc);
      checks++; if (s !== es || co !== full[8] || ov !== eo) begin failures++; $display("FAIL b2b%0d a=%h b=%h sub=%b cin=%b got=%h/%b/%b exp=%h/%b/%b", k, ra, rb, rs, rc, s, co, ov, es, full[8], eo); end
      if (prev >= 0) begin
        checks++; if (acc - prev !== W + 2) begin failures++; $display("FAIL b2b%0d_interval got=%0d exp=%0d", k, acc - prev, W + 2); end
      end
      prev = acc;
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
